// File: rtl/stream_mux_nt1.sv
// N:1 valid/ready stream multiplexer with a one-deep registered output stage.
// Optional packet lock on D_LAST, enabled by defining MUX_LAST_LOCK_EN.
module stream_mux_nt1 #(
  parameter int unsigned n  = 8,
  parameter int unsigned CH = 4,
  parameter int unsigned RR = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [$clog2(CH)-1:0]   SEL,
  input  logic [CH*n-1:0]         D_IN,
  input  logic [CH-1:0]           D_VLD,
  output logic [CH-1:0]           D_RDY,
`ifdef MUX_LAST_LOCK_EN
  input  logic [CH-1:0]           D_LAST,
  output logic                    OUT_LAST,
`endif
  output logic [n-1:0]            D_OUT,
  output logic                    OUT_VLD,
  input  logic                    OUT_RDY,
  output logic [$clog2(CH)-1:0]   GNT_CH
);

  localparam int unsigned SW = $clog2(CH);

  logic          r_out_vld;
  logic [n-1:0]  r_d_out;
  logic [SW-1:0] r_gnt;
  logic [SW-1:0] r_ptr;

  logic          w_ld;
  logic          w_lock;
  logic          w_cand_vld;
  logic [SW-1:0] w_g;
  logic [SW:0]   w_idx;
  logic [SW-1:0] w_ptr_nxt;
  logic [n-1:0]  w_d_sel;

`ifdef MUX_LAST_LOCK_EN
  logic r_lock;
  logic r_last;
  assign w_lock   = r_lock;
  assign OUT_LAST = r_last;
`else
  assign w_lock = 1'b0;
`endif

  assign w_ld = !r_out_vld || OUT_RDY;

  // Candidate selection: lock overrides arbitration; scan runs from the
  // farthest offset down so the channel nearest the pointer wins.
  always_comb begin
    w_g        = '0;
    w_cand_vld = 1'b0;
    w_idx      = '0;
    if (w_lock) begin
      w_g        = r_gnt;
      w_cand_vld = D_VLD[r_gnt];
    end else if (RR != 0) begin
      for (int k = CH - 1; k >= 0; k--) begin
        w_idx = {1'b0, r_ptr} + (SW+1)'(k);
        if (w_idx >= (SW+1)'(CH))
          w_idx = w_idx - (SW+1)'(CH);
        if (D_VLD[w_idx[SW-1:0]]) begin
          w_g        = w_idx[SW-1:0];
          w_cand_vld = 1'b1;
        end
      end
    end else if ({1'b0, SEL} < (SW+1)'(CH)) begin
      w_g        = SEL;
      w_cand_vld = D_VLD[SEL];
    end
  end

  always_comb begin
    D_RDY = '0;
    if (!RST && w_ld && w_cand_vld)
      D_RDY[w_g] = 1'b1;
  end

  assign w_ptr_nxt = (w_g == SW'(CH - 1)) ? '0 : w_g + 1'b1;
  assign w_d_sel   = D_IN[w_g*n +: n];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out_vld <= 1'b0;
      r_d_out   <= '0;
      r_gnt     <= '0;
      r_ptr     <= '0;
`ifdef MUX_LAST_LOCK_EN
      r_lock    <= 1'b0;
      r_last    <= 1'b0;
`endif
    end else if (w_ld) begin
      if (w_cand_vld) begin
        r_out_vld <= 1'b1;
        r_d_out   <= w_d_sel;
        r_gnt     <= w_g;
`ifdef MUX_LAST_LOCK_EN
        r_last    <= D_LAST[w_g];
        // Pointer moves only when a packet completes.
        if (D_LAST[w_g]) begin
          r_lock <= 1'b0;
          if (RR != 0)
            r_ptr <= w_ptr_nxt;
        end else begin
          r_lock <= 1'b1;
        end
`else
        if (RR != 0)
          r_ptr <= w_ptr_nxt;
`endif
      end else begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign D_OUT   = r_d_out;
  assign OUT_VLD = r_out_vld;
  assign GNT_CH  = r_gnt;

endmodule

// File: doc/stream_mux_nt1.md
Name: stream_mux_nt1

Overview:
- Parametrised N:1 stream multiplexer, the successor to the team's combinational 2:1 mux.
- Selects one of CH input channels, each n bits wide with a valid/ready handshake, and registers the selected word into a one-deep output stage.
- Channel choice is either an external select or a built-in round-robin arbiter.
- Sits between multiple producers (e.g. MMIO sources, debug taps) and a single consumer on the memory/IO path.

Parameters:
- n, 8, data width per channel (bits)
- CH, 4, number of input channels; legal range 2..16
- RR, 1, 1 = round-robin arbitration; 0 = external SEL chooses the channel

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  synchronous active-high reset
- SEL  in  $clog2(CH)  channel select, used only when RR=0
- D_IN  in  CH*n  flattened input data; channel i occupies [i*n +: n]
- D_VLD  in  CH  per-channel valid
- D_RDY  out  CH  per-channel ready (combinational)
- D_OUT  out  n  registered output data
- OUT_VLD  out  1  output valid
- OUT_RDY  in  1  consumer ready
- GNT_CH  out  $clog2(CH)  channel index that produced the current D_OUT

Behaviour:
- Reset: synchronous, active-high.
  - One cycle of RST=1 at a CLK edge gives OUT_VLD=0, D_OUT=0, GNT_CH=0, round-robin pointer=0, lock cleared.
  - D_RDY=0 while RST=1.
  - Reset mid-transfer drops the held word; no partial state survives.
- Load enable: ld = !OUT_VLD || OUT_RDY. The output stage accepts a new word in any cycle where ld=1.
- Candidate channel g:
  - RR=1: first i with D_VLD[i]=1, scanning ptr, ptr+1, ... ptr+CH-1 (mod CH).
  - RR=0: g = SEL. If SEL >= CH, there is no candidate.
- D_RDY[i] = ld && candidate valid && (i == g). At most one bit of D_RDY is high per cycle.
- Transfer from channel g: D_OUT <= D_IN[g], GNT_CH <= g, OUT_VLD <= 1. In RR mode, ptr <= (g+1) mod CH.
- No candidate while ld=1: OUT_VLD <= 0 next cycle. D_OUT and GNT_CH hold their last values.
- Latency: exactly 1 cycle from input handshake to OUT_VLD.
- Throughput: 1 word per cycle when OUT_RDY is held high (simultaneous drain and load in the same cycle).
- Stall: while OUT_VLD=1 and OUT_RDY=0:
  - D_OUT, GNT_CH and OUT_VLD are stable;
  - all D_RDY=0;
  - ptr is unchanged.
- Pointer wrap: g = CH-1 sets ptr to 0.
- Fairness: with all channels continuously valid, the grant order is 0,1,...,CH-1,0,...
- RR=0: SEL is sampled only in cycles with ld=1. Changing SEL during a stall has no effect on the held word.
- D_VLD dropping without a handshake is legal; the channel simply loses its candidacy.

Optional Feature:
- Macro: MUX_LAST_LOCK_EN
- Defined:
  - Adds ports D_LAST (in, CH) and OUT_LAST (out, 1; registered alongside D_OUT; reset 0).
  - After a transfer from channel g with D_LAST[g]=0, the grant locks to g; other channels and SEL are ignored.
  - The lock releases after a transfer from g with D_LAST[g]=1.
  - While locked, if D_VLD[g]=0, nothing is granted (bubble); the lock holds.
  - The RR pointer advances only on the LAST beat.
  - RST clears the lock.
- Undefined: no D_LAST/OUT_LAST ports; arbitration occurs independently on every beat.

Test Plan:
- Reset: drive RST=1 one cycle with all D_VLD=1 -> next cycle OUT_VLD=0, D_OUT=0, GNT_CH=0, D_RDY=0000 during reset.
- RR fairness: CH=4, n=8, all D_VLD=1, D_IN ch0..3 = 0x10,0x21,0x32,0x43, OUT_RDY=1 -> D_OUT sequence 0x10,0x21,0x32,0x43,0x10 on consecutive cycles; GNT_CH 0,1,2,3,0.
- Backpressure: output holds 0x21 (GNT_CH=1), OUT_RDY=0 for 3 cycles -> D_OUT=0x21 stable, D_RDY=0000, ptr unchanged; OUT_RDY=1 -> next word 0x32 one cycle later.
- Sparse and wrap: only D_VLD[3] and D_VLD[0] high, ptr=3 -> grant 3 then 0; with only D_VLD[2] high -> repeated grants to ch2, no bubbles.
- Select mode: RR=0, SEL=2, D_IN ch2=0xA5 -> D_OUT=0xA5 one cycle later; SEL changed to 1 during a stall -> D_OUT remains 0xA5 until OUT_RDY.
- Lock (MUX_LAST_LOCK_EN): ch1 sends 3 beats with LAST=0,0,1 while ch0 and ch2 are valid -> GNT_CH=1,1,1 and OUT_LAST=0,0,1, then grant moves to ch2; a RST asserted mid-packet clears the lock so ch0 wins.
